// File: rtl/prio_pending_sched.sv
// Sticky pending-request scheduler: captures req_in rising edges and hands
// out indices highest-first over a valid/ready handshake.
// Ports: clk, rst (async high), ena, req_in[15:0], flush, grant_ready
//        -> grant_valid, grant_idx[7:0], pending[15:0], drop_cnt[7:0], busy.
module prio_pending_sched #(
  parameter int          WIDTH     = 16,
  parameter logic [7:0]  NONE_CODE = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] req_in,
  input  logic             flush,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [7:0]       grant_idx,
  output logic [WIDTH-1:0] pending,
  output logic [7:0]       drop_cnt,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    OFFER
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [7:0]       idx_nx;
  logic [WIDTH-1:0] req_q;
  logic             armed;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] pending_nx;
  logic             accept;
  logic             drop_hit;
  logic [7:0]       hi_idx;

  // armed stays low for the first edge after reset so a level that was
  // already high across reset is absorbed into req_q, not seen as a rise.
  assign rise   = req_in & ~req_q & {WIDTH{ena & armed}};
  assign accept = (state == OFFER) & grant_ready;

  always_comb begin
    clr = '0;
    if (accept)
      clr[grant_idx[IW-1:0]] = 1'b1;
  end

  // Set wins over the accept clear: rise is ORed in after masking.
  assign pending_nx = flush ? '0 : ((pending & ~clr) | rise);
  assign drop_hit   = ~flush & (|(rise & pending & ~clr));

  always_comb begin
    hi_idx = NONE_CODE;
    for (int i = 0; i < WIDTH; i++)
      if (pending[i])
        hi_idx = 8'(i);
  end

  always_comb begin
    state_nx = state;
    idx_nx   = grant_idx;
    if (flush) begin
      state_nx = IDLE;
      idx_nx   = NONE_CODE;
    end else begin
      unique case (state)
        IDLE: begin
          idx_nx = NONE_CODE;
          if ((|pending) && ena)
            state_nx = SELECT;
        end
        SELECT: begin
          if (|pending) begin
            state_nx = OFFER;
            idx_nx   = hi_idx;
          end else begin
            state_nx = IDLE;
            idx_nx   = NONE_CODE;
          end
        end
        OFFER: begin
          if (accept) begin
            idx_nx   = NONE_CODE;
            state_nx = ((|pending_nx) && ena) ? SELECT : IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = NONE_CODE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= NONE_CODE;
    end else begin
      state     <= state_nx;
      grant_idx <= idx_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      armed    <= 1'b0;
      pending  <= '0;
      drop_cnt <= 8'd0;
    end else begin
      req_q   <= req_in;
      armed   <= 1'b1;
      pending <= pending_nx;
      if (drop_hit && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign grant_valid = (state == OFFER);
  assign busy        = (state != IDLE) | (|pending);

endmodule
